// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like two-master arbiter.
// Provides the owner encoding, the default outstanding depth, bus widths
// and the packed request payload that is muxed onto the slave port.
package sram_like_arbiter_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam int unsigned OUTSTANDING_DEFAULT = 2;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  // Request payload presented on the slave side
  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order 1-bit FIFO recording which master owns each accepted transaction.
// Ports:
//   clk, resetn      clock, async active-low reset
//   push_i, din_i    push an owner bit (ignored when full)
//   pop_i            drop the head entry (ignored when empty)
//   head_o           owner of the oldest outstanding transaction
//   full_o, empty_o  occupancy flags
module sram_like_arbiter_owner_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Pointers wrap modulo DEPTH, which need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master (instruction / data) to one-slave arbiter for the sram-like bus.
// The request path is combinational; responses are routed back to the master
// that issued the matching request via an in-order owner FIFO.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   inst_*                           instruction master (read only)
//   data_*                           data master (read/write)
//   mem_*                            shared sram-like slave port
//   arb_err                          sticky: data_ok seen with nothing outstanding
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING = OUTSTANDING_DEFAULT,
  parameter int unsigned OWN_PTR_W   = 1
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_req,
  input  logic [SIZE_W-1:0] inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              arb_err
);

  logic     lock_q, lock_d;
  logic     lock_owner_q, lock_owner_d;
  logic     arb_err_q, arb_err_d;
  logic     grant_c;
  logic     grant_req_c;
  logic     accept_c;
  logic     pop_c;
  logic     fifo_head, fifo_full, fifo_empty;
  mem_req_t inst_pl_c, data_pl_c, mem_pl_c;

  // Grant: a stalled handshake keeps its master; otherwise data has priority
  always_comb begin
    grant_c = inst_req ? OWNER_INST : OWNER_INST;
    if (lock_q) begin
      grant_c = lock_owner_q;
    end else if (data_req) begin
      grant_c = OWNER_DATA;
    end
  end

  assign inst_pl_c = '{wr: 1'b0, size: inst_size, addr: inst_addr, wdata: '0};
  assign data_pl_c = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
  assign mem_pl_c  = (grant_c == OWNER_DATA) ? data_pl_c : inst_pl_c;

  // No bypass when full: a pop in the same cycle does not open a slot
  assign grant_req_c = (grant_c == OWNER_DATA) ? data_req : inst_req;
  assign mem_req     = grant_req_c && !fifo_full;
  assign mem_wr      = mem_pl_c.wr;
  assign mem_size    = mem_pl_c.size;
  assign mem_addr    = mem_pl_c.addr;
  assign mem_wdata   = mem_pl_c.wdata;

  assign accept_c     = mem_req && mem_addr_ok;
  assign inst_addr_ok = accept_c && (grant_c == OWNER_INST);
  assign data_addr_ok = accept_c && (grant_c == OWNER_DATA);

  // Responses go to the owner at the FIFO head; stray data_ok is dropped
  assign pop_c        = mem_data_ok && !fifo_empty;
  assign inst_data_ok = pop_c && (fifo_head == OWNER_INST);
  assign data_data_ok = pop_c && (fifo_head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign arb_err = arb_err_q;

  sram_like_arbiter_owner_fifo #(
    .DEPTH (OUTSTANDING),
    .PTR_W (OWN_PTR_W)
  ) u_owner_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (accept_c),
    .din_i   (grant_c),
    .pop_i   (pop_c),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Lock and error flag next-state
  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    arb_err_d    = arb_err_q;
    if (mem_req && !mem_addr_ok) begin
      lock_d       = 1'b1;
      lock_owner_d = grant_c;
    end else if (accept_c) begin
      lock_d = 1'b0;
    end
    if (mem_data_ok && fifo_empty) begin
      arb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_INST;
      arb_err_q    <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      arb_err_q    <= arb_err_d;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized bench for sram_like_arbiter against a transaction-level model.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  localparam int unsigned OUTS  = 2;
  localparam int unsigned PTR_W = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        arb_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: owners of accepted-but-unanswered transactions, oldest first
  bit          owners[$];
  bit          busy_v;      // a master's request is mid-handshake
  bit          busy_who;
  bit          err_m;
  // Master-side pending requests (held until accepted)
  bit          ip, dp, dwr;
  logic [1:0]  isz, dsz;
  logic [31:0] iad, dad, dwd;

  sram_like_arbiter #(.OUTSTANDING(OUTS), .OWN_PTR_W(PTR_W)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    owners.delete();
    busy_v = 1'b0;
    ip     = 1'b0;
    dp     = 1'b0;
  endtask

  // One cycle: drive at posedge+1, check at posedge+5, then advance the model
  task automatic step(input int unsigned req_pct, input int unsigned aok_pct,
                      input int unsigned dok_pct, input bit force_dok);
    bit gnt, greq, e_req, e_acc, e_pop, head;
    if (!ip && $urandom_range(99) < req_pct) begin
      ip = 1'b1; iad = $urandom; isz = 2'($urandom_range(3));
    end
    if (!dp && $urandom_range(99) < req_pct) begin
      dp = 1'b1; dad = $urandom; dwd = $urandom; dsz = 2'($urandom_range(3));
      dwr = 1'($urandom_range(1));
    end
    inst_req   = ip;  inst_addr = iad; inst_size = isz;
    data_req   = dp;  data_addr = dad; data_size = dsz;
    data_wr    = dwr; data_wdata = dwd;
    mem_addr_ok = ($urandom_range(99) < aok_pct);
    mem_data_ok = force_dok || (owners.size() != 0 && $urandom_range(99) < dok_pct);
    mem_rdata   = $urandom;
    #4;
    gnt   = busy_v ? busy_who : dp;
    greq  = gnt ? dp : ip;
    e_req = greq && (owners.size() < OUTS);
    e_acc = e_req && mem_addr_ok;
    e_pop = mem_data_ok && (owners.size() != 0);
    head  = (owners.size() != 0) ? owners[0] : 1'b0;
    check_val("mem_req", 32'(mem_req), 32'(e_req));
    if (e_req) begin
      check_val("mem_addr", mem_addr, gnt ? dad : iad);
      check_val("mem_size", 32'(mem_size), 32'(gnt ? dsz : isz));
      check_val("mem_wr", 32'(mem_wr), 32'(gnt ? dwr : 1'b0));
      check_val("mem_wdata", mem_wdata, gnt ? dwd : 32'h0);
    end
    check_val("inst_addr_ok", 32'(inst_addr_ok), 32'(e_acc && !gnt));
    check_val("data_addr_ok", 32'(data_addr_ok), 32'(e_acc && gnt));
    check_val("inst_data_ok", 32'(inst_data_ok), 32'(e_pop && !head));
    check_val("data_data_ok", 32'(data_data_ok), 32'(e_pop && head));
    if (e_pop) begin
      check_val(head ? "data_rdata" : "inst_rdata", head ? data_rdata : inst_rdata, mem_rdata);
    end
    check_val("arb_err", 32'(arb_err), 32'(err_m));
    if (mem_data_ok && owners.size() == 0) err_m = 1'b1;
    if (e_pop) void'(owners.pop_front());
    if (e_acc) begin
      owners.push_back(gnt);
      busy_v = 1'b0;
      if (gnt) dp = 1'b0; else ip = 1'b0;
    end else if (e_req) begin
      busy_v   = 1'b1;
      busy_who = gnt;
    end
    @(posedge clk); #1;
  endtask

  // Asynchronous reset away from any clock edge; arb_err must clear at once
  task automatic async_reset();
    #2;
    resetn = 1'b0;
    #1;
    check_val("arb_err_async_clr", 32'(arb_err), 32'h0);
    check_val("mem_req_in_reset", 32'(mem_req && !inst_req && !data_req), 32'h0);
    model_clear();
    err_m = 1'b0;
    inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 1'b0; inst_size = '0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    model_clear();
    err_m = 1'b0; dwr = 1'b0; isz = '0; dsz = '0; iad = '0; dad = '0; dwd = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_mem_req", 32'(mem_req), 32'h0);
    check_val("rst_inst_addr_ok", 32'(inst_addr_ok), 32'h0);
    check_val("rst_data_addr_ok", 32'(data_addr_ok), 32'h0);
    check_val("rst_inst_data_ok", 32'(inst_data_ok), 32'h0);
    check_val("rst_data_data_ok", 32'(data_data_ok), 32'h0);
    check_val("rst_arb_err", 32'(arb_err), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Mixed traffic, fast slave
    repeat (400) step(60, 80, 60, 1'b0);
    // Slow address phase: exercises lock across stalls
    repeat (400) step(70, 25, 50, 1'b0);
    // Slow responses: FIFO fills and mem_req is throttled
    repeat (400) step(80, 90, 15, 1'b0);

    // Drain, then stray data_ok with an empty FIFO
    for (int i = 0; i < 200 && (owners.size() != 0 || busy_v); i++) step(0, 100, 100, 1'b0);
    check_val("drained", 32'(owners.size()), 32'h0);
    step(0, 100, 0, 1'b1);
    repeat (3) step(0, 100, 0, 1'b0);
    check_val("arb_err_sticky", 32'(arb_err), 32'h1);
    async_reset();

    // Fill with outstanding transactions then reset mid-operation
    for (int i = 0; i < 200 && owners.size() < OUTS; i++) step(100, 100, 0, 1'b0);
    check_val("filled", 32'(owners.size()), 32'(OUTS));
    async_reset();
    repeat (400) step(60, 70, 50, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
